// File: rtl/vga2_frame_arbiter.sv
// vga2_frame_arbiter: shares one single-port framebuffer RAM between the raster
// fetch path, which keeps a small first-word fall-through pixel FIFO topped up,
// and host pixel writes. The host is held off only while the FIFO is close to
// draining (urgent fetch) or during a frame restart.
module vga2_frame_arbiter #(
    parameter int AddrSize  = 19,
    parameter int FrameSize = 480000,
    parameter int FifoLog   = 3,
    parameter int LowMark   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                pix_pop,
    output logic [2:0]          pix_rgb,
    output logic                pix_valid,
    output logic                underflow,
    input  logic                host_wr,
    input  logic [AddrSize-1:0] host_addr,
    input  logic [2:0]          host_rgb,
    output logic                host_ready,
    output logic                ram_en,
    output logic                ram_we,
    output logic [AddrSize-1:0] ram_addr,
    output logic [2:0]          ram_wdata,
    input  logic [2:0]          ram_rdata
);

    localparam int Depth = 1 << FifoLog;
    localparam int CntW  = FifoLog + 1;

    // One extra bit so occupancy + inflight can never wrap.
    typedef logic [CntW:0] level_t;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_FETCH,
        OP_WRITE
    } op_e;

    logic [2:0]          fifo_q [Depth];
    logic [2:0]          fifo_d [Depth];
    logic [FifoLog-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FifoLog-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                inflight_q, inflight_d;
    logic                underflow_q, underflow_d;
    logic [AddrSize-1:0] fetch_addr_q, fetch_addr_d;

    level_t level;
    logic   need;
    logic   urgent;
    op_e    op;
    logic   push;
    logic   pop_ok;
    logic   pop_bad;

    // Fill level counts the read already issued so the FIFO can never overfill.
    always_comb begin
        level  = level_t'(count_q) + level_t'(inflight_q);
        need   = (level < level_t'(Depth));
        urgent = need && (level <= level_t'(LowMark));
    end

    // Host handshake is independent of host_wr so the host can look before it leaps.
    always_comb begin
        host_ready = !urgent && !frame_start && !reset;
    end

    // Per-cycle arbitration: urgent fetch, then host write, then opportunistic fetch.
    always_comb begin
        op = OP_IDLE;
        if (!reset && !frame_start) begin
            if (urgent)
                op = OP_FETCH;
            else if (host_wr && host_ready)
                op = OP_WRITE;
            else if (need)
                op = OP_FETCH;
        end
    end

    // RAM port is driven straight from the arbitration result; idle drives zeros.
    always_comb begin
        ram_en    = (op != OP_IDLE);
        ram_we    = (op == OP_WRITE);
        ram_addr  = '0;
        ram_wdata = '0;
        if (op == OP_FETCH) begin
            ram_addr = fetch_addr_q;
        end else if (op == OP_WRITE) begin
            ram_addr  = host_addr;
            ram_wdata = host_rgb;
        end
    end

    // Display side view of the FIFO head; pix_rgb holds while the FIFO is empty.
    always_comb begin
        pix_valid = (count_q != '0);
        pix_rgb   = fifo_q[rd_ptr_q];
        underflow = underflow_q;
    end

    // Next-state for FIFO, fetch pointer and sticky underflow; frame_start flushes everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        fifo_d       = fifo_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        inflight_d   = 1'b0;
        fetch_addr_d = fetch_addr_q;

        push    = inflight_q && !frame_start;
        pop_ok  = pix_pop && !frame_start && (count_q != '0);
        pop_bad = pix_pop && !frame_start && (count_q == '0);

        underflow_d = underflow_q || pop_bad;

        if (frame_start) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = ram_rdata;
                wr_ptr_d         = wr_ptr_q + 1'b1;
            end
            if (pop_ok)
                rd_ptr_d = rd_ptr_q + 1'b1;

            case ({push, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            if (op == OP_FETCH) begin
                inflight_d = 1'b1;
                if (fetch_addr_q == AddrSize'(FrameSize - 1))
                    fetch_addr_d = '0;
                else
                    fetch_addr_d = fetch_addr_q + 1'b1;
            end
        end
    end

    // State registers; reset also clears in-flight so a read abandoned by reset is never pushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the FIFO storage is reset too, so pix_rgb reads a defined 0 while empty.
            for (int i = 0; i < Depth; i++)
                fifo_q[i] <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            underflow_q  <= 1'b0;
            fetch_addr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            fifo_q       <= fifo_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            underflow_q  <= underflow_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

endmodule
